// File: rtl/piso_out_pkg.sv
// piso_out_pkg
//   Shared constants for the parallel-in / serial-out output stage.
//   DEFAULT_WIDTH    : bits per tap word
//   DEFAULT_NUM_TAPS : number of words held and serialized
//   Producer and consumer blocks import these so their word geometry
//   matches the serializer without repeating the numbers.
package piso_out_pkg;

    localparam int unsigned DEFAULT_WIDTH    = 8;
    localparam int unsigned DEFAULT_NUM_TAPS = 4;

endpackage : piso_out_pkg

// File: rtl/piso_out_if.sv
// piso_out_if
//   Bus bundle between the word producer and the serializer.
//   SHIFT_OUT   : mode select, 0 = parallel load, 1 = shift
//   EN_PISO_OUT : shift enable, only meaningful when SHIFT_OUT = 1
//   DATA_IN     : WIDTH*NUM_TAPS parallel words, word k at [k*WIDTH +: WIDTH]
//   DATA_OUT    : current serial output word
//   master drives the controls and words; slave (the serializer) drives DATA_OUT.
interface piso_out_if
    import piso_out_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned NUM_TAPS = DEFAULT_NUM_TAPS
);

    logic                      SHIFT_OUT;
    logic                      EN_PISO_OUT;
    logic [WIDTH*NUM_TAPS-1:0] DATA_IN;
    logic [WIDTH-1:0]          DATA_OUT;

    modport master (
        output SHIFT_OUT,
        output EN_PISO_OUT,
        output DATA_IN,
        input  DATA_OUT
    );

    modport slave (
        input  SHIFT_OUT,
        input  EN_PISO_OUT,
        input  DATA_IN,
        output DATA_OUT
    );

endinterface : piso_out_if

// File: rtl/piso_out.sv
// piso_out
//   Parallel-in / serial-out word serializer.
//   CLKEXT       : clock, all state changes on the rising edge
//   CLR_PISO_OUT : asynchronous active-low clear of every tap word
//   bus          : piso_out_if slave (SHIFT_OUT, EN_PISO_OUT, DATA_IN, DATA_OUT)
//   A load captures all NUM_TAPS words at once; DATA_OUT always shows the
//   top word, so the serial order is word NUM_TAPS-1 down to word 0.
//   Each enabled shift moves words up one tap and zero-fills tap 0, so once
//   all words are drained DATA_OUT stays 0 until the next load.
module piso_out
    import piso_out_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned NUM_TAPS = DEFAULT_NUM_TAPS
) (
    input  logic       CLKEXT,
    input  logic       CLR_PISO_OUT,
    piso_out_if.slave  bus
);

    logic [WIDTH-1:0] words    [NUM_TAPS];
    logic [WIDTH-1:0] reg_data [NUM_TAPS];

    // Split the flat parallel bus into tap words.
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_word
        assign words[k] = bus.DATA_IN[k*WIDTH +: WIDTH];
    end

    always_ff @(posedge CLKEXT or negedge CLR_PISO_OUT) begin
        if (!CLR_PISO_OUT) begin
            for (int unsigned k = 0; k < NUM_TAPS; k++) begin
                reg_data[k] <= '0;
            end
        end else if (!bus.SHIFT_OUT) begin
            // Load ignores EN_PISO_OUT and overrides any partial shift.
            for (int unsigned k = 0; k < NUM_TAPS; k++) begin
                reg_data[k] <= words[k];
            end
        end else if (bus.EN_PISO_OUT) begin
            // With a single tap the loop is empty and the shift just clears it.
            for (int unsigned k = 1; k < NUM_TAPS; k++) begin
                reg_data[k] <= reg_data[k-1];
            end
            reg_data[0] <= '0;
        end
    end

    assign bus.DATA_OUT = reg_data[NUM_TAPS-1];

endmodule : piso_out

// File: tb/tb_piso_out.sv
// tb_piso_out
//   Directed bench for piso_out: a default 8x4 instance and a 4x1 instance
//   sharing clock and reset, checked with immediate assertions against
//   hand-computed words.
module tb_piso_out;

    logic clk;
    logic rst_n;

    int unsigned passed;
    int unsigned total;

    piso_out_if #(.WIDTH(8), .NUM_TAPS(4)) bus  ();
    piso_out_if #(.WIDTH(4), .NUM_TAPS(1)) bus1 ();

    piso_out #(.WIDTH(8), .NUM_TAPS(4)) dut (
        .CLKEXT       (clk),
        .CLR_PISO_OUT (rst_n),
        .bus          (bus)
    );

    piso_out #(.WIDTH(4), .NUM_TAPS(1)) dut1 (
        .CLKEXT       (clk),
        .CLR_PISO_OUT (rst_n),
        .bus          (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] expected);
        total++;
        assert (bus.DATA_OUT === expected) passed++;
        else $error("FAIL %s: observed %02h expected %02h", tag, bus.DATA_OUT, expected);
    endtask

    task automatic check1(input string tag, input logic [3:0] expected);
        total++;
        assert (bus1.DATA_OUT === expected) passed++;
        else $error("FAIL %s: observed %01h expected %01h", tag, bus1.DATA_OUT, expected);
    endtask

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;

        // Reset asserted with random words in load mode.
        rst_n            = 1'b0;
        bus.SHIFT_OUT    = 1'b0;
        bus.EN_PISO_OUT  = 1'b0;
        bus.DATA_IN      = {$urandom, $urandom};
        bus1.SHIFT_OUT   = 1'b0;
        bus1.EN_PISO_OUT = 1'b0;
        bus1.DATA_IN     = 4'h7;
        #2;
        check("reset_immediate", 8'h00);
        check1("t1_reset_immediate", 4'h0);
        for (int i = 0; i < 3; i++) begin
            bus.DATA_IN = {$urandom, $urandom};
            tick();
            check("reset_held_edge", 8'h00);
        end

        // Release away from the edge, then load {AA,BB,CC,DD}.
        #2 rst_n = 1'b1;
        bus.DATA_IN = 32'hAABBCCDD;
        tick();
        check("load_aa", 8'hAA);

        // Drain; DATA_IN changes during shift must be ignored.
        bus.SHIFT_OUT   = 1'b1;
        bus.EN_PISO_OUT = 1'b1;
        bus.DATA_IN     = 32'h5A5A5A5A;
        tick(); check("shift1_bb", 8'hBB);
        bus.DATA_IN = 32'hFFFFFFFF;
        tick(); check("shift2_cc", 8'hCC);
        tick(); check("shift3_dd", 8'hDD);
        tick(); check("shift4_zero", 8'h00);
        tick(); check("shift5_zero", 8'h00);

        // Hold with enable low in shift mode.
        bus.SHIFT_OUT = 1'b0;
        bus.DATA_IN   = 32'h11223344;
        tick(); check("load_11", 8'h11);
        bus.SHIFT_OUT   = 1'b1;
        bus.EN_PISO_OUT = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_11", 8'h11);
        end
        bus.EN_PISO_OUT = 1'b1;
        tick(); check("shift_22", 8'h22);

        // Async reset mid-shift, between edges.
        bus.SHIFT_OUT = 1'b0;
        bus.DATA_IN   = 32'hAABBCCDD;
        tick(); check("reload_aa", 8'hAA);
        bus.SHIFT_OUT = 1'b1;
        tick(); check("mid_bb", 8'hBB);
        tick(); check("mid_cc", 8'hCC);
        #2 rst_n = 1'b0;
        #1 check("async_clear", 8'h00);
        #1 rst_n = 1'b1;
        tick(); check("post_reset_shift1", 8'h00);
        tick(); check("post_reset_shift2", 8'h00);

        // Load overrides partial shift.
        bus.SHIFT_OUT = 1'b0;
        tick(); check("reload2_aa", 8'hAA);
        bus.SHIFT_OUT = 1'b1;
        tick(); check("mid2_bb", 8'hBB);
        bus.SHIFT_OUT = 1'b0;
        bus.DATA_IN   = 32'h01020304;
        tick(); check("override_01", 8'h01);
        bus.SHIFT_OUT = 1'b1;
        tick(); check("ovr_shift_02", 8'h02);
        tick(); check("ovr_shift_03", 8'h03);
        tick(); check("ovr_shift_04", 8'h04);
        tick(); check("ovr_shift_00", 8'h00);

        // Single-tap instance: load, hold, shift clears.
        bus1.SHIFT_OUT = 1'b0;
        bus1.DATA_IN   = 4'hA;
        tick(); check1("t1_load_a", 4'hA);
        bus1.SHIFT_OUT   = 1'b1;
        bus1.EN_PISO_OUT = 1'b0;
        bus1.DATA_IN     = 4'h3;
        tick(); check1("t1_hold_a", 4'hA);
        bus1.EN_PISO_OUT = 1'b1;
        tick(); check1("t1_shift_clear", 4'h0);
        tick(); check1("t1_shift_stays0", 4'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_piso_out

// File: doc/piso_out.md
PISO_OUT -- requirements
Module: piso_out

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning bits per tap word.
REQ-002 The block SHALL have parameter NUM_TAPS, default 4, meaning number of words held and serialized.
REQ-003 The block SHALL have port CLKEXT  input  1  clock; all state changes on its rising edge.
REQ-004 The block SHALL have port CLR_PISO_OUT  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port SHIFT_OUT  input  1  mode select: 0 = parallel load, 1 = shift.
REQ-006 The block SHALL have port EN_PISO_OUT  input  1  shift enable, qualifies shift mode only.
REQ-007 The block SHALL have port DATA_IN  input  WIDTH*NUM_TAPS  parallel words; word k = DATA_IN[k*WIDTH +: WIDTH].
REQ-008 The block SHALL have port DATA_OUT  output  WIDTH  current serial output word.

Function
REQ-009 The block SHALL hold an internal array reg_data[0..NUM_TAPS-1] of WIDTH-bit words.
REQ-010 DATA_OUT SHALL equal reg_data[NUM_TAPS-1] combinationally, with no extra register stage.
REQ-011 With SHIFT_OUT=0, each rising edge SHALL load reg_data[k] from word k of DATA_IN, for all k, regardless of EN_PISO_OUT.
REQ-012 With SHIFT_OUT=1 and EN_PISO_OUT=1, each rising edge SHALL perform reg_data[k] <= reg_data[k-1] for k=NUM_TAPS-1 down to 1, and reg_data[0] <= 0.
REQ-013 With SHIFT_OUT=1 and EN_PISO_OUT=0, all reg_data words SHALL hold.
REQ-014 Serial output order after a load SHALL be word NUM_TAPS-1 first, then NUM_TAPS-2, and so on down to word 0.
REQ-015 Load-to-output latency SHALL be one edge: the highest word is visible on DATA_OUT after the loading edge.
REQ-016 Each enabled shift edge SHALL advance DATA_OUT to the next lower word.
REQ-017 After NUM_TAPS enabled shifts with no reload, DATA_OUT SHALL be 0 and SHALL stay 0 on further shifts; zero-fill is the only behaviour, with no wrap-around.
REQ-018 A load SHALL override any partially shifted content, with no handshake or busy indication.
REQ-019 Changes on DATA_IN while SHIFT_OUT=1 SHALL have no effect on reg_data or DATA_OUT.
REQ-020 All parameter values with WIDTH>=1 and NUM_TAPS>=1 SHALL be supported.
REQ-021 For NUM_TAPS=1, a shift SHALL simply clear the single word.

Reset
REQ-022 CLR_PISO_OUT=0 SHALL immediately clear all reg_data words to 0, without waiting for a clock edge, so DATA_OUT=0.
REQ-023 Reset SHALL dominate load and shift, including assertion mid-shift; prior content SHALL be lost.
REQ-024 After CLR_PISO_OUT returns to 1, normal operation SHALL resume on the next rising edge, with the registers still at 0 until a load occurs.

Structure
REQ-025 The block SHALL be a single module containing one always block for the register array, an async-reset branch, and a generate/for loop over taps.
REQ-026 The default WIDTH and NUM_TAPS constants SHALL reside in the shared NPU package for reuse by the producer and consumer blocks.
REQ-027 No sub-module SHALL be used; an optional per-tap word register may be factored as submodule piso_tap_reg.

Verification
REQ-028 Assert CLR_PISO_OUT=0 with random DATA_IN -> DATA_OUT=00 immediately and on every edge while asserted.
REQ-029 Release reset, apply DATA_IN={AA,BB,CC,DD} with SHIFT_OUT=0 for one edge -> DATA_OUT=AA.
REQ-030 Set SHIFT_OUT=1 and EN_PISO_OUT=1 for 4 edges -> DATA_OUT sequence BB, CC, DD, 00; a 5th edge -> 00.
REQ-031 Load {11,22,33,44}, then SHIFT_OUT=1 with EN_PISO_OUT=0 for 3 edges -> DATA_OUT stays 11; then enable for 1 edge -> 22.
REQ-032 Mid-shift (DATA_OUT=CC), assert reset asynchronously between edges -> DATA_OUT=00 at once; release, then shift -> remains 00.
REQ-033 Mid-shift, drop SHIFT_OUT to 0 with DATA_IN={01,02,03,04} -> next edge DATA_OUT=01, and subsequent shifts -> 02, 03, 04.
